// File: rtl/conv_out_writer.sv
// conv_out_writer: ReLU + saturating requantise of 24-bit accumulations to 8 bits, then RAM write.
// `CONV_OUT_POOL_EN adds 2x2 max pooling per filter map; addr_err flags producer address slips.
module conv_out_writer #(
  parameter int img_size    = 8'h1C,
  parameter int filter_size = 4'b0110,
  parameter int SHIFT       = 5'd8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic signed [23:0] in_data,
  input  logic [12:0]        in_addr,
  output logic               out_we,
  output logic [12:0]        out_addr,
  output logic [7:0]         out_data,
  output logic               busy,
  output logic               done,
  output logic               addr_err
);
  localparam int CW = (img_size > 1) ? $clog2(img_size) : 1;
  localparam int FW = (filter_size > 1) ? $clog2(filter_size) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(img_size - 1);
  localparam logic [FW-1:0] FLT_LAST = FW'(filter_size - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]         state;
  logic [CW-1:0]      col, row;
  logic [FW-1:0]      filter;
  logic [12:0]        exp_addr, wr_cnt;
  logic               accept, last_smp;
  logic signed [23:0] shifted;
  logic [7:0]         rq;
  logic               s1_vld, s1_last, out_last;
  logic [7:0]         s1_q;

  assign accept   = (state == S_RUN) && in_valid;
  assign last_smp = (col == COL_LAST) && (row == COL_LAST) && (filter == FLT_LAST);
  assign busy     = (state == S_RUN) || (state == S_FLUSH);
  assign done     = (state == S_DONE);
  assign shifted  = in_data >>> SHIFT;

  always_comb begin
    rq = 8'd0;
    if (in_data > 24'sd0) rq = (|shifted[23:8]) ? 8'hFF : shifted[7:0];
  end

`ifdef CONV_OUT_POOL_EN
  localparam int HN = img_size / 2;
  localparam int HW = (HN > 1) ? $clog2(HN) : 1;
  logic          s1_col_odd, s1_row_odd;
  logic [HW-1:0] s1_half;
  logic [7:0]    h, pmax, lmax;
  logic [7:0]    linebuf [HN];

  assign pmax = (h > s1_q) ? h : s1_q;
  assign lmax = (linebuf[s1_half] > pmax) ? linebuf[s1_half] : pmax;

  // Line buffer needs no reset: every entry is rewritten on an even row before it is read.
  always_ff @(posedge clk) begin
    if (s1_vld && s1_col_odd && !s1_row_odd) linebuf[s1_half] <= pmax;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      col      <= '0;
      row      <= '0;
      filter   <= '0;
      exp_addr <= '0;
      wr_cnt   <= '0;
      addr_err <= 1'b0;
      s1_vld   <= 1'b0;
      s1_last  <= 1'b0;
      s1_q     <= 8'd0;
      out_we   <= 1'b0;
      out_addr <= '0;
      out_data <= 8'd0;
      out_last <= 1'b0;
`ifdef CONV_OUT_POOL_EN
      s1_col_odd <= 1'b0;
      s1_row_odd <= 1'b0;
      s1_half    <= '0;
      h          <= 8'd0;
`endif
    end else begin
      s1_vld <= accept;
      out_we <= 1'b0;
      case (state)
        S_IDLE: if (start) begin
          col      <= '0;
          row      <= '0;
          filter   <= '0;
          exp_addr <= '0;
          wr_cnt   <= '0;
          addr_err <= 1'b0;
          state    <= S_RUN;
        end
        S_RUN: if (accept) begin
          if (in_addr != exp_addr) addr_err <= 1'b1;
          exp_addr <= exp_addr + 13'd1;
          if (col == COL_LAST) begin
            col <= '0;
            if (row == COL_LAST) begin
              row    <= '0;
              filter <= (filter == FLT_LAST) ? '0 : filter + 1'b1;
            end else begin
              row <= row + 1'b1;
            end
          end else begin
            col <= col + 1'b1;
          end
          if (last_smp) state <= S_FLUSH;
        end
        S_FLUSH: if (out_we && out_last) state <= S_DONE;
        default: state <= S_IDLE;
      endcase

      if (accept) begin
        s1_q    <= rq;
        s1_last <= last_smp;
`ifdef CONV_OUT_POOL_EN
        s1_col_odd <= col[0];
        s1_row_odd <= row[0];
        s1_half    <= HW'(col >> 1);
`endif
      end

      if (s1_vld) begin
`ifdef CONV_OUT_POOL_EN
        if (!s1_col_odd) begin
          h <= s1_q;
        end else if (s1_row_odd) begin
          out_we   <= 1'b1;
          out_addr <= wr_cnt;
          out_data <= lmax;
          out_last <= s1_last;
          wr_cnt   <= wr_cnt + 13'd1;
        end
`else
        out_we   <= 1'b1;
        out_addr <= wr_cnt;
        out_data <= s1_q;
        out_last <= s1_last;
        wr_cnt   <= wr_cnt + 13'd1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_conv_out_writer.sv
// Directed bench for conv_out_writer: a 4x4x1 instance for hand-computed vectors and a
// default 28x28x6 instance for full-length, address-error and mid-run reset runs.
`timescale 1ns/1ps
module tb_conv_out_writer;
`ifdef CONV_OUT_POOL_EN
  localparam bit POOL = 1'b1;
`else
  localparam bit POOL = 1'b0;
`endif
  localparam int LN = 28 * 28 * 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic s_start, s_vld, s_we, s_busy, s_done, s_err;
  logic [23:0] s_data;
  logic [12:0] s_addr_in, s_addr;
  logic [7:0]  s_dat;
  logic l_start, l_vld, l_we, l_busy, l_done, l_err;
  logic [23:0] l_data;
  logic [12:0] l_addr_in, l_addr;
  logic [7:0]  l_dat;

  conv_out_writer #(.img_size(4), .filter_size(1), .SHIFT(8)) dut_s (
    .clk(clk), .rst(rst), .start(s_start), .in_valid(s_vld), .in_data(s_data),
    .in_addr(s_addr_in), .out_we(s_we), .out_addr(s_addr), .out_data(s_dat),
    .busy(s_busy), .done(s_done), .addr_err(s_err));

  conv_out_writer dut_l (
    .clk(clk), .rst(rst), .start(l_start), .in_valid(l_vld), .in_data(l_data),
    .in_addr(l_addr_in), .out_we(l_we), .out_addr(l_addr), .out_data(l_dat),
    .busy(l_busy), .done(l_done), .addr_err(l_err));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0, failures = 0;
  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Write/done capture (actual values only).
  int s_wa[$], s_wd[$], s_wc[$], s_dc[$], s_db[$];
  int l_wa[$], l_wd[$], l_wc[$], l_dc[$], l_db[$];
  always @(negedge clk) begin
    if (s_we) begin s_wa.push_back(int'(s_addr)); s_wd.push_back(int'(s_dat)); s_wc.push_back(cyc); end
    if (s_done) begin s_dc.push_back(cyc); s_db.push_back(int'(s_busy)); end
    if (l_we) begin l_wa.push_back(int'(l_addr)); l_wd.push_back(int'(l_dat)); l_wc.push_back(cyc); end
    if (l_done) begin l_dc.push_back(cyc); l_db.push_back(int'(l_busy)); end
  end

  logic [23:0] s_vec [16];
  int          s_exp [$];
  int          l_exp [$];
  int          l_q   [LN];

  function automatic bit s_completes(input int i);
    return !POOL || (((i % 4) % 2 == 1) && ((i / 4) % 2 == 1));
  endfunction

  function automatic bit l_completes(input int i);
    return !POOL || (((i % 28) % 2 == 1) && (((i / 28) % 28) % 2 == 1));
  endfunction

  function automatic logic [23:0] l_vec(input int i);
    int v;
    v = (i * 37) % 300;
    if (i % 5 == 0) return 24'(-(v << 8));
    return 24'(v << 8);
  endfunction

  task automatic run_s(input int gap, input int skip_at, input bit mid_start, input bit start_vld);
    int iss[$];
    int n;
    s_wa.delete(); s_wd.delete(); s_wc.delete(); s_dc.delete(); s_db.delete();
    s_start = 1'b1; s_vld = start_vld; s_data = 24'h7FFFFF; s_addr_in = '0;
    @(posedge clk); #1;
    s_start = 1'b0; s_vld = 1'b0;
    check("s_err_clr", int'(s_err), 0);
    for (int i = 0; i < 16; i++) begin
      if (skip_at >= 0 && i == skip_at) check("s_err_pre", int'(s_err), 0);
      if (skip_at >= 0 && i == skip_at + 1) check("s_err_set", int'(s_err), 1);
      s_vld = 1'b1; s_data = s_vec[i];
      s_addr_in = 13'(i + ((skip_at >= 0 && i >= skip_at) ? 1 : 0));
      s_start = mid_start && (i == 6);
      if (s_completes(i)) iss.push_back(cyc);
      @(posedge clk); #1;
      s_vld = 1'b0; s_start = 1'b0;
      repeat (gap - 1) begin @(posedge clk); #1; end
    end
    n = 0;
    while (s_dc.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("s_done_cnt", s_dc.size(), 1);
    check("s_nwr", s_wa.size(), s_exp.size());
    for (int k = 0; k < s_exp.size() && k < s_wa.size(); k++) begin
      check($sformatf("s_addr%0d", k), s_wa[k], k);
      check($sformatf("s_data%0d", k), s_wd[k], s_exp[k]);
      check($sformatf("s_lat%0d", k), s_wc[k], iss[k] + 2);
    end
    if (s_dc.size() > 0 && s_wc.size() > 0) begin
      check("s_done_cyc", s_dc[0], s_wc[s_wc.size() - 1] + 1);
      check("s_busy_at_done", s_db[0], 0);
    end
    check("s_busy_after", int'(s_busy), 0);
    check("s_err_end", int'(s_err), (skip_at >= 0) ? 1 : 0);
  endtask

  task automatic run_l(input int abort_at);
    int iss[$];
    int n, bad, snap;
    l_wa.delete(); l_wd.delete(); l_wc.delete(); l_dc.delete(); l_db.delete();
    l_start = 1'b1;
    @(posedge clk); #1;
    l_start = 1'b0;
    for (int i = 0; i < LN; i++) begin
      l_vld = 1'b1; l_data = l_vec(i); l_addr_in = 13'(i);
      if (l_completes(i)) iss.push_back(cyc);
      @(posedge clk); #1;
      l_vld = 1'b0;
      if (i == abort_at) begin
        snap = l_wa.size();
        rst = 1'b1;
        #1;
        check("l_rst_we", int'(l_we), 0);
        check("l_rst_addr", int'(l_addr), 0);
        check("l_rst_data", int'(l_dat), 0);
        check("l_rst_busy", int'(l_busy), 0);
        check("l_rst_done", int'(l_done), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("l_no_wr_after_rst", l_wa.size(), snap);
        check("l_idle_after_rst", int'(l_busy), 0);
        return;
      end
    end
    n = 0;
    while (l_dc.size() == 0 && n < 20) begin @(posedge clk); #1; n++; end
    check("l_done_cnt", l_dc.size(), 1);
    check("l_nwr", l_wa.size(), l_exp.size());
    bad = 0;
    for (int k = 0; k < l_exp.size() && k < l_wa.size(); k++)
      if (l_wa[k] != k || l_wd[k] != l_exp[k] || l_wc[k] != iss[k] + 2) bad++;
    check("l_bad_writes", bad, 0);
    if (l_wa.size() > 0) check("l_last_addr", l_wa[l_wa.size() - 1], l_exp.size() - 1);
    if (l_dc.size() > 0 && l_wc.size() > 0) begin
      check("l_done_cyc", l_dc[0], l_wc[l_wc.size() - 1] + 1);
      check("l_busy_at_done", l_db[0], 0);
    end
    repeat (5) @(posedge clk);
    #1;
    check("l_busy_after", int'(l_busy), 0);
    check("l_err_end", int'(l_err), 0);
  endtask

  initial begin
    int v, m;
    rst = 1'b1;
    s_start = 0; s_vld = 0; s_data = '0; s_addr_in = '0;
    l_start = 0; l_vld = 0; l_data = '0; l_addr_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_s_we", int'(s_we), 0);
    check("rst_s_addr", int'(s_addr), 0);
    check("rst_s_data", int'(s_dat), 0);
    check("rst_s_busy", int'(s_busy), 0);
    check("rst_s_done", int'(s_done), 0);
    check("rst_s_err", int'(s_err), 0);
    check("rst_l_we", int'(l_we), 0);
    check("rst_l_busy", int'(l_busy), 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Ramp 0..15 << 8, full rate.
    for (int i = 0; i < 16; i++) s_vec[i] = 24'(i << 8);
    if (POOL) s_exp = '{5, 7, 13, 15};
    else      s_exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    run_s(1, -1, 1'b0, 1'b0);

    // Requantise corners, 1-in-3 valid, stray start mid-run.
    s_vec = '{24'h000180, 24'h0000FF, 24'h7FFFFF, 24'hFFFF00,
              24'h000000, 24'h00FFFF, 24'h010000, 24'h800000,
              24'h000100, 24'h0001FF, 24'h00FE00, 24'h00FF80,
              24'h00AB12, 24'h000200, 24'hFFFFFF, 24'h400000};
    if (POOL) s_exp = '{255, 255, 171, 255};
    else      s_exp = '{1, 0, 255, 0, 0, 255, 255, 0, 1, 1, 254, 255, 171, 2, 0, 255};
    run_s(3, -1, 1'b1, 1'b0);

    // Address skip at sample 10; then start+in_valid together clears the flag and drops the sample.
    for (int i = 0; i < 16; i++) s_vec[i] = 24'(i << 8);
    if (POOL) s_exp = '{5, 7, 13, 15};
    else      s_exp = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    run_s(1, 10, 1'b0, 1'b0);
    run_s(1, -1, 1'b0, 1'b1);

    for (int i = 0; i < LN; i++) begin
      v = (i * 37) % 300;
      l_q[i] = (i % 5 == 0) ? 0 : ((v > 255) ? 255 : v);
    end
    l_exp.delete();
    if (POOL) begin
      for (int f = 0; f < 6; f++)
        for (int r = 0; r < 14; r++)
          for (int c = 0; c < 14; c++) begin
            m = 0;
            for (int dr = 0; dr < 2; dr++)
              for (int dc = 0; dc < 2; dc++)
                if (l_q[f*784 + (2*r+dr)*28 + 2*c+dc] > m) m = l_q[f*784 + (2*r+dr)*28 + 2*c+dc];
            l_exp.push_back(m);
          end
    end else begin
      for (int i = 0; i < LN; i++) l_exp.push_back(l_q[i]);
    end
    run_l(-1);
    run_l(50);
    run_l(-1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
